// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing and data width.
// The matching transmitter uses the same package.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;
  localparam int UART_DATA_W         = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset high so that a line in reset looks idle.
module uart_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a valid/ready output holding register.
// Frames with a low stop bit raise FRAME_ERR; bytes arriving while the register is full raise OVERRUN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   UART_RX,
  output logic [UART_DATA_W-1:0] DATA,
  output logic                   VALID,
  input  logic                   READY,
  output logic                   FRAME_ERR,
  output logic                   OVERRUN
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_W);

  localparam logic [CW-1:0]    C_HALF   = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    C_LAST   = CW'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);

  uart_rx_state_t r_state;
  uart_rx_state_t w_state_next;

  logic [CW-1:0]          r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_rxs;
  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_shift_en;
  logic w_deliver;
  logic w_frame_err;

  uart_sync u_sync (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_async (UART_RX),
    .o_sync  (w_rxs)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rxs) w_state_next = RX_START;
      end
      // A start bit must still be low at its midpoint, otherwise it was a glitch.
      RX_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_clr    = 1'b1;
          w_idx_clr    = 1'b1;
          w_state_next = w_rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == IDX_LAST) w_state_next = RX_STOP;
        end
      end
      // Leaving mid-stop-bit lets the next start edge be caught without a gap.
      RX_STOP: begin
        if (r_cnt == C_LAST) begin
          w_cnt_clr = 1'b1;
          if (w_rxs) begin
            w_deliver    = 1'b1;
            w_state_next = RX_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        w_cnt_clr = 1'b1;
        if (w_rxs) w_state_next = RX_IDLE;
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_state_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_shift_en) r_shift[r_idx] <= w_rxs;
    end
  end

  // A new byte may replace the held one only when the consumer takes the old one that same cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || READY) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign DATA      = r_data;
  assign VALID     = r_valid;
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit.
// Expected bytes go into a scoreboard queue as frames are sent and are popped on each VALID&&READY handshake.
module tb_uart_receiver;

  logic       CLK;
  logic       RSTN;
  logic       UART_RX;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;
  logic       FRAME_ERR;
  logic       OVERRUN;

  int asserts     = 0;
  int failures    = 0;
  int cycleCnt    = 0;
  int validCycles = 0;
  int ferrCount   = 0;
  int ovrCount    = 0;
  int riseCount   = 0;
  int lastRise    = 0;
  logic prevValid = 1'b0;
  logic [7:0] sbq[$];

  uart_receiver #(.CLK_PER_BIT(16)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .UART_RX   (UART_RX),
    .DATA      (DATA),
    .VALID     (VALID),
    .READY     (READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCnt++;

  // Output monitor: sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge CLK) begin
    logic [7:0] exp;
    if (RSTN) begin
      if (VALID) validCycles++;
      if (FRAME_ERR) ferrCount++;
      if (OVERRUN) ovrCount++;
      if (VALID && !prevValid) begin
        riseCount++;
        lastRise = cycleCnt;
      end
      if (VALID && READY) begin
        asserts++;
        if (sbq.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_underflow: got DATA=%02h with no byte expected", DATA);
        end else begin
          exp = sbq.pop_front();
          if (DATA !== exp) begin
            failures++;
            $display("[TB] FAIL sb_data: got %02h expected %02h", DATA, exp);
          end
        end
      end
    end
    prevValid = VALID;
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clearCounters();
    validCycles = 0;
    ferrCount   = 0;
    ovrCount    = 0;
    riseCount   = 0;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    UART_RX = 1'b0;
    waitCycles(16);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      waitCycles(16);
    end
    UART_RX = stopBit;
    waitCycles(16);
  endtask

  task automatic checkCounts(input string tag, input int expRise, input int expFerr, input int expOvr);
    asserts++;
    if (riseCount !== expRise) begin
      failures++;
      $display("[TB] FAIL %s_valid_rises: got %0d expected %0d", tag, riseCount, expRise);
    end
    asserts++;
    if (ferrCount !== expFerr) begin
      failures++;
      $display("[TB] FAIL %s_frame_err: got %0d expected %0d", tag, ferrCount, expFerr);
    end
    asserts++;
    if (ovrCount !== expOvr) begin
      failures++;
      $display("[TB] FAIL %s_overrun: got %0d expected %0d", tag, ovrCount, expOvr);
    end
    asserts++;
    if (sbq.size() !== 0) begin
      failures++;
      $display("[TB] FAIL %s_sb_left: got %0d expected 0", tag, sbq.size());
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    RSTN    = 1'b0;
    UART_RX = 1'b1;
    READY   = 1'b0;
    waitCycles(4);
    asserts++;
    if ({DATA, VALID, FRAME_ERR, OVERRUN} !== 11'h000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got DATA=%02h V=%b FE=%b OV=%b expected 00/0/0/0",
               DATA, VALID, FRAME_ERR, OVERRUN);
    end
    RSTN = 1'b1;
    waitCycles(4);
  endtask

  task automatic test_basic();
    int c0;
    int lat;
    $display("[TB] test_basic");
    READY = 1'b1;
    clearCounters();
    sbq.push_back(8'hA5);
    c0 = cycleCnt;
    sendFrame(8'hA5, 1'b1);
    waitCycles(20);
    lat = lastRise - c0;
    asserts++;
    if (lat < 154 || lat > 156) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d expected 155 +/-1", lat);
    end
    asserts++;
    if (validCycles !== 1) begin
      failures++;
      $display("[TB] FAIL basic_valid_width: got %0d expected 1", validCycles);
    end
    checkCounts("basic", 1, 0, 0);
  endtask

  task automatic test_glitch();
    $display("[TB] test_glitch");
    READY = 1'b1;
    clearCounters();
    UART_RX = 1'b0;
    waitCycles(5);
    UART_RX = 1'b1;
    waitCycles(40);
    checkCounts("glitch", 0, 0, 0);
    clearCounters();
    sbq.push_back(8'h3C);
    sendFrame(8'h3C, 1'b1);
    waitCycles(20);
    checkCounts("after_glitch", 1, 0, 0);
  endtask

  task automatic test_frame_err();
    $display("[TB] test_frame_err");
    READY = 1'b1;
    clearCounters();
    sendFrame(8'h55, 1'b0);
    waitCycles(24);
    UART_RX = 1'b1;
    waitCycles(20);
    checkCounts("frame_err", 0, 1, 0);
    clearCounters();
    sbq.push_back(8'h81);
    sendFrame(8'h81, 1'b1);
    waitCycles(20);
    checkCounts("after_ferr", 1, 0, 0);
  endtask

  task automatic test_overrun();
    $display("[TB] test_overrun");
    READY = 1'b0;
    clearCounters();
    sbq.push_back(8'h01);
    sendFrame(8'h01, 1'b1);
    sendFrame(8'hFE, 1'b1);
    waitCycles(20);
    asserts++;
    if (VALID !== 1'b1 || DATA !== 8'h01) begin
      failures++;
      $display("[TB] FAIL overrun_hold: got V=%b DATA=%02h expected 1/01", VALID, DATA);
    end
    READY = 1'b1;
    waitCycles(4);
    asserts++;
    if (VALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_release: got V=%b expected 0", VALID);
    end
    checkCounts("overrun", 1, 0, 1);
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    READY = 1'b0;
    clearCounters();
    sbq.push_back(8'h11);
    sbq.push_back(8'h22);
    // Second delivery lands 160+155 cycles after the first start edge.
    fork
      begin
        sendFrame(8'h11, 1'b1);
        sendFrame(8'h22, 1'b1);
      end
      begin
        waitCycles(314);
        READY = 1'b1;
      end
    join
    waitCycles(20);
    checkCounts("back_to_back", 1, 0, 0);
    READY = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    $display("[TB] test_reset_mid_frame");
    READY = 1'b1;
    clearCounters();
    fork
      sendFrame(8'hF0, 1'b1);
      begin
        waitCycles(16 + 64 + 8);
        RSTN = 1'b0;
        waitCycles(2);
        asserts++;
        if ({DATA, VALID, FRAME_ERR, OVERRUN} !== 11'h000) begin
          failures++;
          $display("[TB] FAIL midreset_outputs: got DATA=%02h V=%b FE=%b OV=%b expected 00/0/0/0",
                   DATA, VALID, FRAME_ERR, OVERRUN);
        end
        RSTN = 1'b1;
      end
    join
    waitCycles(40);
    checkCounts("midreset", 0, 0, 0);
    clearCounters();
    sbq.push_back(8'h7E);
    sendFrame(8'h7E, 1'b1);
    waitCycles(20);
    checkCounts("after_reset", 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
